// File: rtl/mem_ctrl_port.sv
// rtl/mem_ctrl_port.sv - byte-serial MEM-stage load/store responder for an 8-bit synchronous RAM
// Optional misalignment trap: define MEM_MISALIGN_CHK_EN.
module mem_ctrl_port #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic [31:0]       mem_req_addr,
    input  logic [31:0]       mem_req_data,
    input  logic [3:0]        mem_req_type,
    output logic              mem_busy,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              mem_err,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        type_q, type_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       rdata_q, rdata_d;

    logic       req_valid;
    logic       req_misaligned;
    logic [2:0] cur_n;
    logic       is_store;
    logic       access_active;
    logic [1:0] lane;
    logic       unused_addr_hi;

    function automatic logic [2:0] size_of(input logic [3:0] t);
        case (t)
            4'd1, 4'd4, 4'd6: return 3'd1;
            4'd2, 4'd5, 4'd7: return 3'd2;
            default:          return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [3:0] t, input logic [31:0] b);
        case (t)
            4'd1:    return {{24{b[7]}}, b[7:0]};
            4'd2:    return {{16{b[15]}}, b[15:0]};
            4'd4:    return {24'd0, b[7:0]};
            4'd5:    return {16'd0, b[15:0]};
            default: return b;
        endcase
    endfunction

    assign unused_addr_hi = ^mem_req_addr[31:ADDR_W];
    assign req_valid      = (mem_req_type >= 4'd1) && (mem_req_type <= 4'd8);
    assign cur_n          = size_of(type_q);
    assign is_store       = (type_q >= 4'd6);
    assign lane           = cnt_q[1:0] - 2'd1;
    // A trapped (misaligned) access spends its ACCESS cycle idle on the RAM side.
    assign access_active  = (state_q == S_ACCESS) && !err_q && (cnt_q < cur_n);

`ifdef MEM_MISALIGN_CHK_EN
    logic [2:0] req_n;
    assign req_n          = size_of(mem_req_type);
    assign req_misaligned = ((req_n == 3'd2) && mem_req_addr[0]) ||
                            ((req_n == 3'd4) && (mem_req_addr[1:0] != 2'b00));
    assign mem_err        = (state_q == S_DONE) && err_q;
`else
    assign req_misaligned = 1'b0;
    assign mem_err        = 1'b0;
`endif

    assign mem_busy  = (state_q != S_IDLE);
    assign mem_done  = (state_q == S_DONE);
    assign mem_rdata = rdata_q;
    assign ram_a     = access_active ? addr_q + ADDR_W'(cnt_q) : '0;
    assign ram_dout  = (access_active && is_store) ? data_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
    // Gated by rst so a reset arriving mid-store stops the write in that same cycle.
    assign ram_wr    = access_active && is_store && !rst;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req && req_valid) begin
                    addr_d  = mem_req_addr[ADDR_W-1:0];
                    data_d  = mem_req_data;
                    type_d  = mem_req_type;
                    cnt_d   = 3'd0;
                    err_d   = req_misaligned;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (err_q) begin
                    state_d = S_DONE;
                end else if (is_store) begin
                    if (cnt_q == cur_n - 3'd1) state_d = S_DONE;
                    else                       cnt_d   = cnt_q + 3'd1;
                end else begin
                    if (cnt_q != 3'd0) rbuf_d[{lane, 3'b000} +: 8] = ram_din;
                    if (cnt_q == cur_n) begin
                        state_d = S_DONE;
                        rdata_d = extend(type_q, rbuf_d);
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
